// File: rtl/par_data_out.sv
// par_data_out: serialises 32-bit FIFO values as MSB-first bytes on the parallel transfer port; define PAR_OUT_CHECKSUM_EN to append an XOR checksum byte per gate
module par_data_out #(
  parameter int GATE_VALUES = 4,
  parameter int DIV = 4
) (
  input  logic        CLK_EXT,
  input  logic        ENABLE,
  input  logic        start,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_rd,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  input  logic        clr_underrun,
  output logic        DATA_CLK,
  output logic [7:0]  DATA_OUT,
  output logic        ROI_SYNC,
  output logic        HARM_SYNC
);
  localparam int PW = $clog2(DIV);
  typedef enum logic [2:0] {IDLE, WAIT_DATA, FETCH, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] val_q, val_d;
  logic [31:0] sh_q, sh_d, hold_q, hold_d, ck_sh;
  logic have_q, have_d, pf_q, sent_q, sent_d, ur_q, ur_d, ck_q;
  logic byte_end, val_end, last_val, pf_rd, pf_miss, nxt_rdy;
  assign byte_end = state_q == SHIFT && ph_q == PW'(DIV - 1);
  assign val_end  = byte_end && byte_q == 2'd3;
  assign last_val = val_q == 8'(GATE_VALUES - 1);
  assign pf_rd    = state_q == SHIFT && byte_q == 2'd3 && ph_q == '0 && !last_val && !fifo_empty;
  assign pf_miss  = state_q == SHIFT && byte_q == 2'd3 && ph_q == '0 && !last_val && fifo_empty;
  assign nxt_rdy  = have_q || pf_q;
`ifdef PAR_OUT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
  logic [7:0] cs_q;
  // XOR every transmitted data byte; ck_q marks the trailing checksum byte
  always_ff @(posedge CLK_EXT or negedge ENABLE)
    if (!ENABLE) begin
      cs_q <= '0;
      ck_q <= 1'b0;
    end else if (state_d == DONE) begin
      cs_q <= '0;
      ck_q <= 1'b0;
    end else if (byte_end && !ck_q) begin
      cs_q <= cs_q ^ sh_q[31:24];
      ck_q <= val_end && last_val;
    end
  assign ck_sh = {cs_q ^ sh_q[31:24], 24'h0};
`else
  localparam bit CK_EN = 1'b0;
  assign ck_q  = 1'b0;
  assign ck_sh = '0;
`endif
  // State and datapath registers; ENABLE low aborts everything at once
  always_ff @(posedge CLK_EXT or negedge ENABLE)
    if (!ENABLE) begin
      state_q <= IDLE;
      ph_q    <= '0;
      byte_q  <= '0;
      val_q   <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      have_q  <= 1'b0;
      pf_q    <= 1'b0;
      sent_q  <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      byte_q  <= byte_d;
      val_q   <= val_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      have_q  <= have_d;
      pf_q    <= pf_rd;
      sent_q  <= sent_d;
      ur_q    <= ur_d;
    end
  // Next-state decode; a value boundary without prefetched data stalls in WAIT_DATA
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = fifo_empty ? WAIT_DATA : FETCH;
      WAIT_DATA: if (!fifo_empty) state_d = FETCH;
      FETCH:     state_d = LOAD;
      LOAD:      state_d = SHIFT;
      SHIFT:     if (ck_q ? byte_end : val_end)
                   state_d = ck_q ? DONE : last_val ? (CK_EN ? SHIFT : DONE) : nxt_rdy ? SHIFT : WAIT_DATA;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // Byte timing, shift register, prefetch holding register and sticky underrun
  always_comb begin
    ph_d   = ph_q;
    byte_d = byte_q;
    val_d  = val_q;
    sh_d   = sh_q;
    hold_d = pf_q ? fifo_data : hold_q;
    have_d = have_q || pf_q;
    sent_d = sent_q || state_q == SHIFT;
    ur_d   = pf_miss ? 1'b1 : clr_underrun ? 1'b0 : ur_q;
    if (state_q == LOAD) begin
      sh_d   = fifo_data;
      ph_d   = '0;
      byte_d = '0;
    end
    if (state_q == SHIFT) begin
      ph_d = byte_end ? '0 : ph_q + 1'b1;
      if (byte_end) begin
        byte_d = byte_q + 1'b1;
        sh_d   = sh_q << 8;
      end
      if (val_end) begin
        val_d  = val_q + 1'b1;
        sh_d   = last_val ? ck_sh : have_q ? hold_q : pf_q ? fifo_data : sh_q;
        have_d = 1'b0;
      end
    end
    if (state_d == DONE) begin
      sh_d   = '0;
      val_d  = '0;
      byte_d = '0;
      ph_d   = '0;
      have_d = 1'b0;
      sent_d = 1'b0;
    end
  end
  // Port decode from state; ROI_SYNC stays up through a mid-gate stall once a byte has gone out
  always_comb begin
    fifo_rd   = state_q == FETCH || pf_rd;
    busy      = state_q != IDLE && state_q != DONE;
    done      = state_q == DONE;
    underrun  = ur_q;
    DATA_CLK  = state_q == SHIFT && ph_q >= PW'(DIV / 2);
    DATA_OUT  = sh_q[31:24];
    ROI_SYNC  = busy && (state_q == SHIFT || sent_q);
    HARM_SYNC = state_q == SHIFT && byte_q == 2'd0 && !ck_q;
  end
endmodule

// File: tb/tb_par_data_out.sv
// tb_par_data_out: directed checks of par_data_out with a queue-backed FIFO and a DATA_CLK host sampler
module tb_par_data_out;
`ifdef PAR_OUT_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk = 1'b0, enable = 1'b0, start = 1'b0, clr_ur = 1'b0;
  logic fifo_empty, fifo_rd, busy, done, underrun, dclk, roi, harm;
  logic [31:0] fifo_data = '0;
  logic [7:0] dout;
  logic [31:0] fq[$];
  logic [8:0] hb[$];
  logic [8:0] exp_b [9];
  logic [7:0] cs;
  logic dclk_prev, done_roi;
  logic [7:0] done_dout;
  int cyc, roi_n, done_n, rd_n, rd_cyc, done_cyc, rise_cyc;
  int n_assert = 0, n_fail = 0;

  par_data_out #(.GATE_VALUES(2), .DIV(4)) dut (
    .CLK_EXT(clk), .ENABLE(enable), .start(start), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .busy(busy), .done(done),
    .underrun(underrun), .clr_underrun(clr_ur), .DATA_CLK(dclk),
    .DATA_OUT(dout), .ROI_SYNC(roi), .HARM_SYNC(harm)
  );

  always #5 clk = ~clk;
  assign fifo_empty = (fq.size() == 0);
  always @(posedge clk) if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; roi_n = 0; done_n = 0; rd_n = 0; rd_cyc = 0; done_cyc = 0; rise_cyc = 0;
    hb.delete();
    dclk_prev = dclk;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (roi) roi_n++;
      if (done) begin done_n++; done_cyc = cyc; done_roi = roi; done_dout = dout; end
      if (fifo_rd) begin rd_n++; rd_cyc = cyc; end
      if (dclk && !dclk_prev) begin
        hb.push_back({harm, dout});
        if (rise_cyc == 0) rise_cyc = cyc;
      end
      dclk_prev = dclk;
    end
  endtask

  function automatic logic [8:0] hbyte(input int i);
    return (i < hb.size()) ? hb[i] : 9'h1FF;
  endfunction

  initial begin
    exp_b[0] = 9'h111; exp_b[1] = 9'h022; exp_b[2] = 9'h033; exp_b[3] = 9'h044;
    exp_b[4] = 9'h1A5; exp_b[5] = 9'h0B6; exp_b[6] = 9'h0C7; exp_b[7] = 9'h0D8;
    cs = '0;
    for (int i = 0; i < 8; i++) cs ^= exp_b[i][7:0];
    exp_b[8] = {1'b0, cs};
    // reset held with start high: nothing moves
    fq.push_back(32'h11223344); fq.push_back(32'hA5B6C7D8);
    start = 1'b1;
    clr_stats();
    tick(3);
    chk("reset_outputs", {fifo_rd, busy, done, underrun, dclk, roi, harm, dout}, '0);
    chk("reset_no_rd", rd_n, 0);
    start = 1'b0;
    #2 enable = 1'b1;
    clr_stats();
    tick(3);
    chk("idle_no_rd", rd_n, 0);
    chk("idle_not_busy", busy, 0);
    // nominal gate
    start = 1'b1;
    clr_stats();
    tick(1);
    start = 1'b0;
    chk("fetch_rd", {fifo_rd, busy}, 2'b11);
    tick(2);
    chk("first_byte", {roi, harm, dclk, dout}, {3'b110, 8'h11});
    tick(42);
    chk("nom_nbytes", hb.size(), NB);
    for (int i = 0; i < NB; i++) chk($sformatf("nom_byte%0d", i), hbyte(i), exp_b[i]);
    chk("nom_first_rise", rise_cyc, 5);
    chk("nom_roi_cycles", roi_n, NB * 4);
    chk("nom_done_count", done_n, 1);
    chk("nom_done_cycle", done_cyc, 3 + NB * 4);
    chk("nom_done_idle_outs", {done_roi, done_dout}, '0);
    chk("nom_rd_count", rd_n, 2);
    chk("nom_prefetch_cycle", rd_cyc, 15);
    chk("nom_end_idle", {busy, roi, dclk}, '0);
    // start with empty FIFO
    start = 1'b1;
    clr_stats();
    tick(1);
    start = 1'b0;
    tick(19);
    chk("wait_busy", busy, 1);
    chk("wait_no_roi", roi_n, 0);
    chk("wait_no_rd", rd_n, 0);
    fq.push_back(32'h00000002); fq.push_back(32'hDEADBEEF);
    tick(45);
    chk("wait_underrun", underrun, 0);
    chk("wait_done", done_n, 1);
    chk("wait_nbytes", hb.size(), NB);
    chk("wait_byte3", hbyte(3), 9'h002);
    chk("wait_byte4", hbyte(4), 9'h1DE);
    chk("wait_roi_cycles", roi_n, NB * 4);
    // mid-gate underrun; clear pulsed on the setting cycle must lose
    fq.push_back(32'h01020304);
    start = 1'b1;
    clr_stats();
    tick(1);
    start = 1'b0;
    tick(14);
    clr_ur = 1'b1;
    tick(1);
    clr_ur = 1'b0;
    chk("ur_set_beats_clr", underrun, 1);
    tick(14);
    chk("ur_stall_outs", {busy, roi, dclk, underrun}, 4'b1101);
    chk("ur_stall_bytes", hb.size(), 4);
    chk("ur_stall_no_done", done_n, 0);
    fq.push_back(32'h05060708);
    tick(40);
    chk("ur_done", done_n, 1);
    chk("ur_nbytes", hb.size(), NB);
    chk("ur_byte4", hbyte(4), 9'h105);
    chk("ur_byte7", hbyte(7), 9'h008);
    chk("ur_sticky", underrun, 1);
    clr_ur = 1'b1;
    tick(1);
    clr_ur = 1'b0;
    chk("ur_cleared", underrun, 0);
    // second start ignored, then abort at byte 2
    fq.push_back(32'hCAFEBABE); fq.push_back(32'h12345678);
    start = 1'b1;
    clr_stats();
    tick(1);
    start = 1'b0;
    tick(7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("abort_byte2", dout, 8'hBA);
    chk("ignore_start_rd", rd_n, 1);
    enable = 1'b0;
    #1;
    chk("abort_outputs", {fifo_rd, busy, done, underrun, dclk, roi, harm, dout}, '0);
    fq.delete();
    #2 enable = 1'b1;
    tick(1);
    fq.push_back(32'h0A0B0C0D); fq.push_back(32'h10203040);
    start = 1'b1;
    clr_stats();
    tick(1);
    start = 1'b0;
    tick(44);
    chk("restart_done", done_n, 1);
    chk("restart_nbytes", hb.size(), NB);
    chk("restart_byte0", hbyte(0), 9'h10A);
    chk("restart_byte7", hbyte(7), 9'h040);
    chk("restart_rd", rd_n, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
